// File: rtl/kd_tree_pkg.sv
// Shared types and constants for the KD-tree internal-node loader.
package kd_tree_pkg;

  localparam int unsigned INTERNAL_WIDTH    = 22;
  localparam int unsigned HALF_WIDTH        = 11;
  localparam int unsigned HALF_SEL_BIT      = 11;
  localparam int unsigned NUM_NODES_MAX     = 63;
  localparam int unsigned NODE_CNT_WIDTH    = 6;
  localparam int unsigned WB_ADDRESS_OFFSET = 495;
  localparam int unsigned WB_ADR_WIDTH      = 32;
  localparam int unsigned WB_DAT_WIDTH      = 32;
  localparam int unsigned WB_SEL_WIDTH      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WR_LO,
    ST_WR_HI,
    ST_RD_LO,
    ST_RD_HI,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

  typedef struct packed {
    logic [HALF_WIDTH-1:0] idx;
    logic [HALF_WIDTH-1:0] median;
  } node_rec_t;

  // A zero count still loads one node; larger counts are capped at the tree size.
  function automatic logic [NODE_CNT_WIDTH-1:0] clamp_nodes(input logic [NODE_CNT_WIDTH-1:0] n);
    if (n == '0) begin
      return NODE_CNT_WIDTH'(1);
    end
    if (32'(n) > NUM_NODES_MAX) begin
      return NODE_CNT_WIDTH'(NUM_NODES_MAX);
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Counts cycles spent waiting for a Wishbone ack and flags when the budget is spent.
module wb_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired_c
);

  localparam int unsigned CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_WIDTH-1:0] cnt_q;

  assign expired_c = (cnt_q == CNT_WIDTH'(ACK_TIMEOUT));

  // Wait counter: cleared on beat entry, holds once the budget is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count && !expired_c) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/kd_tree_wb_loader.sv
// Wishbone master that writes streamed KD-tree node records into the tree, with optional readback check.
module kd_tree_wb_loader
  import kd_tree_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NODE_CNT_WIDTH-1:0] num_nodes,
  input  logic                      verify_en,
  input  logic                      node_valid,
  input  logic [INTERNAL_WIDTH-1:0] node_data,
  output logic                      node_ready,
  output logic                      wb_mode,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [WB_SEL_WIDTH-1:0]   wbm_sel_o,
  output logic [WB_ADR_WIDTH-1:0]   wbm_adr_o,
  output logic [WB_DAT_WIDTH-1:0]   wbm_dat_o,
  input  logic                      wbm_ack_i,
  input  logic [WB_DAT_WIDTH-1:0]   wbm_dat_i,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [NODE_CNT_WIDTH-1:0] mismatch_cnt
);

  loader_state_t             state_q, state_d;
  logic                      phase_q, phase_d;
  logic                      verify_q, verify_d;
  logic [NODE_CNT_WIDTH-1:0] num_q, num_d;
  logic [NODE_CNT_WIDTH-1:0] node_cnt_q, node_cnt_d;
  node_rec_t                 rec_q, rec_d;
  node_rec_t                 rb_q, rb_d;
  logic                      terr_d;
  logic [NODE_CNT_WIDTH-1:0] mm_d;
  logic                      advance;
  logic                      timer_load, timer_count, timer_expired_c;
  logic                      ack_seen;
  logic                      half_sel_d;
  logic [HALF_WIDTH-1:0]     half_d;
  logic                      cyc_d, we_d, busy_d;
  logic [WB_ADR_WIDTH-1:0]   adr_d;
  logic [WB_DAT_WIDTH-1:0]   dat_d;
  logic                      unused_dat_c;

  assign wbm_sel_o    = '1;
  assign unused_dat_c = ^wbm_dat_i[WB_DAT_WIDTH-1:HALF_WIDTH];
  // An ack only counts while a strobe is actually on the bus.
  assign ack_seen     = wbm_ack_i && wbm_stb_o;

  wb_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .count     (timer_count),
    .expired_c (timer_expired_c)
  );

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d     = state_q;
    phase_d     = 1'b0;
    verify_d    = verify_q;
    num_d       = num_q;
    node_cnt_d  = node_cnt_q;
    rec_d       = rec_q;
    rb_d        = rb_q;
    terr_d      = timeout_err;
    mm_d        = mismatch_cnt;
    advance     = 1'b0;
    timer_load  = 1'b0;
    timer_count = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          verify_d   = verify_en;
          num_d      = clamp_nodes(num_nodes);
          node_cnt_d = '0;
          terr_d     = 1'b0;
          mm_d       = '0;
          rb_d       = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (node_valid && node_ready) begin
          rec_d   = node_data;
          state_d = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        // The tree never acks the low half, so this beat is exactly one cycle.
        state_d = ST_WR_HI;
      end
      ST_WR_HI, ST_RD_LO, ST_RD_HI: begin
        // Phase 0 is the idle gap between beats; phase 1 holds the strobe until ack.
        if (!phase_q) begin
          phase_d    = 1'b1;
          timer_load = 1'b1;
        end else if (ack_seen) begin
          case (state_q)
            ST_WR_HI: begin
              if (verify_q) begin
                state_d = ST_RD_LO;
              end else begin
                advance = 1'b1;
              end
            end
            ST_RD_LO: begin
              rb_d.median = wbm_dat_i[HALF_WIDTH-1:0];
              state_d     = ST_RD_HI;
            end
            default: begin
              rb_d.idx = wbm_dat_i[HALF_WIDTH-1:0];
              state_d  = ST_CHECK;
            end
          endcase
        end else if (timer_expired_c) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          phase_d     = 1'b1;
          timer_count = 1'b1;
        end
      end
      ST_CHECK: begin
        if ((rb_q != rec_q) && (mismatch_cnt != NODE_CNT_WIDTH'(NUM_NODES_MAX))) begin
          mm_d = mismatch_cnt + NODE_CNT_WIDTH'(1);
        end
        advance = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      node_cnt_d = node_cnt_q + NODE_CNT_WIDTH'(1);
      state_d    = (node_cnt_d == num_q) ? ST_DONE : ST_FETCH;
    end

    busy_d     = (state_d != ST_IDLE);
    cyc_d      = (state_d == ST_WR_LO) ||
                 (((state_d == ST_WR_HI) || (state_d == ST_RD_LO) || (state_d == ST_RD_HI)) && phase_d);
    we_d       = cyc_d && ((state_d == ST_WR_LO) || (state_d == ST_WR_HI));
    half_sel_d = (state_d == ST_WR_HI) || (state_d == ST_RD_HI);
    half_d     = half_sel_d ? rec_d.idx : rec_d.median;
    adr_d      = busy_d ? (WB_ADR_WIDTH'(WB_ADDRESS_OFFSET) + WB_ADR_WIDTH'(node_cnt_d)) : '0;
    dat_d      = cyc_d ? WB_DAT_WIDTH'({half_sel_d, half_d}) : '0;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      verify_q     <= 1'b0;
      num_q        <= '0;
      node_cnt_q   <= '0;
      rec_q        <= '0;
      rb_q         <= '0;
      node_ready   <= 1'b0;
      wb_mode      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      timeout_err  <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      verify_q     <= verify_d;
      num_q        <= num_d;
      node_cnt_q   <= node_cnt_d;
      rec_q        <= rec_d;
      rb_q         <= rb_d;
      node_ready   <= (state_d == ST_FETCH);
      wb_mode      <= busy_d;
      busy         <= busy_d;
      done         <= (state_d == ST_DONE);
      wbm_cyc_o    <= cyc_d;
      wbm_stb_o    <= cyc_d;
      wbm_we_o     <= we_d;
      wbm_adr_o    <= adr_d;
      wbm_dat_o    <= dat_d;
      timeout_err  <= terr_d;
      mismatch_cnt <= mm_d;
    end
  end

endmodule

// File: tb/tb_kd_tree_wb_loader.sv
// Scoreboard bench for kd_tree_wb_loader with a small internal_node_tree slave model.
module tb_kd_tree_wb_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_nodes = '0;
  logic        verify_en = 1'b0;
  logic        node_valid = 1'b0;
  logic [21:0] node_data = '0;
  logic        node_ready, wb_mode, wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy, done, timeout_err;
  logic [5:0]  mismatch_cnt;

  always #5 clk = ~clk;

  kd_tree_wb_loader #(.ACK_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_nodes    (num_nodes),
    .verify_en    (verify_en),
    .node_valid   (node_valid),
    .node_data    (node_data),
    .node_ready   (node_ready),
    .wb_mode      (wb_mode),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_dat_i    (wbm_dat_i),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .mismatch_cnt (mismatch_cnt)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic stb_prev = 1'b0;
  int wr_beats = 0;
  int rd_beats = 0;

  // Hand-computed write data per node: low beat {0,median}, high beat {1,idx}.
  logic [21:0] recs[3] = '{22'h000001, 22'h3FFFFF, 22'h155AAA};
  logic [31:0] exp_lo[3] = '{32'h001, 32'h7FF, 32'h2AA};
  logic [31:0] exp_hi[3] = '{32'h800, 32'hFFF, 32'hAAB};

  // Slave model knobs.
  logic [21:0] mem[0:63];
  logic [10:0] lo_buf = '0;
  logic        ack_r = 1'b0;
  logic [31:0] rd_data = '0;
  logic        ack_low_mode = 1'b0;
  logic        no_ack_hi = 1'b0;
  logic        corrupt_en = 1'b0;
  logic        spur_ack = 1'b0;
  int          corrupt_node = 1;

  assign wbm_ack_i = ack_r | spur_ack;
  assign wbm_dat_i = rd_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tree slave: low write latched silently, high write commits the record and acks.
  always @(posedge clk) begin
    int idx;
    logic [10:0] rd;
    idx = int'(wbm_adr_o) - 495;
    ack_r <= 1'b0;
    if (wbm_cyc_o && wbm_stb_o && !ack_r && idx >= 0 && idx < 64) begin
      if (wbm_we_o) begin
        if (!wbm_dat_o[11]) begin
          lo_buf <= wbm_dat_o[10:0];
          if (ack_low_mode) ack_r <= 1'b1;
        end else if (!(no_ack_hi && idx == 0)) begin
          mem[idx] <= {wbm_dat_o[10:0], lo_buf};
          ack_r    <= 1'b1;
        end
      end else begin
        rd = wbm_dat_o[11] ? mem[idx][21:11] : mem[idx][10:0];
        if (corrupt_en && idx == corrupt_node && !wbm_dat_o[11]) rd = rd ^ 11'h008;
        rd_data <= {21'b0, rd};
        ack_r   <= 1'b1;
      end
    end
  end

  // Monitor: every new write beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [63:0] e;
    if (wbm_stb_o && !stb_prev) begin
      chk("cyc_with_stb", {63'b0, wbm_cyc_o}, 64'd1);
      if (wbm_we_o) begin
        wr_beats++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: adr %0h dat %0h with empty scoreboard", wbm_adr_o, wbm_dat_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_adr", {32'b0, wbm_adr_o}, {32'b0, e[63:32]});
          chk("wr_dat", {32'b0, wbm_dat_o}, {32'b0, e[31:0]});
          chk("wr_sel", {60'b0, wbm_sel_o}, 64'hF);
        end
      end else begin
        rd_beats++;
      end
    end
    stb_prev <= wbm_stb_o;
  end

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(495 + i), exp_lo[i]});
      exp_q.push_back({32'(495 + i), exp_hi[i]});
    end
  endtask

  task automatic pulse_start(input logic [5:0] n, input logic v);
    @(negedge clk);
    start = 1'b1;
    num_nodes = n;
    verify_en = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_rec(input logic [21:0] d);
    bit ok;
    ok = 1'b0;
    node_valid = 1'b1;
    node_data = d;
    for (int k = 0; k < 300; k++) begin
      if (node_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: node_ready never seen for record %0h", d);
      node_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 node_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {63'b0, ok}, 64'd1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, beats0;
    bit found, any_ready;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cyc", {63'b0, wbm_cyc_o}, 64'd0);
    chk("rst_stb", {63'b0, wbm_stb_o}, 64'd0);
    chk("rst_we", {63'b0, wbm_we_o}, 64'd0);
    chk("rst_sel", {60'b0, wbm_sel_o}, 64'hF);
    chk("rst_adr", {32'b0, wbm_adr_o}, 64'd0);
    chk("rst_dat", {32'b0, wbm_dat_o}, 64'd0);
    chk("rst_ready", {63'b0, node_ready}, 64'd0);
    chk("rst_wb_mode", {63'b0, wb_mode}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_terr", {63'b0, timeout_err}, 64'd0);
    chk("rst_mm", {58'b0, mismatch_cnt}, 64'd0);
    rst_n = 1'b1;

    // 1: three nodes, no verify; slave also acks the low half, which must be ignored
    ack_low_mode = 1'b1;
    push_writes(3);
    pulse_start(6'd3, 1'b0);
    chk("t1_wb_mode", {63'b0, wb_mode}, 64'd1);
    for (int i = 0; i < 3; i++) send_rec(recs[i]);
    wait_done("t1");
    chk("t1_all_writes", 64'(exp_q.size()), 64'd0);
    chk("t1_wb_mode_low", {63'b0, wb_mode}, 64'd0);
    chk("t1_busy_low", {63'b0, busy}, 64'd0);
    ack_low_mode = 1'b0;

    // 2: verify against a clean slave
    rd0 = rd_beats;
    push_writes(3);
    pulse_start(6'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_rec(recs[i]);
    wait_done("t2");
    chk("t2_all_writes", 64'(exp_q.size()), 64'd0);
    chk("t2_read_beats", 64'(rd_beats - rd0), 64'd6);
    chk("t2_mismatch", {58'b0, mismatch_cnt}, 64'd0);
    for (int i = 0; i < 3; i++) chk("t2_tree_contents", {42'b0, mem[i]}, {42'b0, recs[i]});

    // 3: slave corrupts bit 3 of node 1 low readback
    corrupt_en = 1'b1;
    push_writes(3);
    pulse_start(6'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_rec(recs[i]);
    wait_done("t3");
    corrupt_en = 1'b0;
    chk("t3_all_writes", 64'(exp_q.size()), 64'd0);
    chk("t3_mismatch", {58'b0, mismatch_cnt}, 64'd1);
    for (int i = 0; i < 3; i++) chk("t3_tree_contents", {42'b0, mem[i]}, {42'b0, recs[i]});

    // 4: high half of node 0 never acked -> abort
    no_ack_hi = 1'b1;
    push_writes(1);
    pulse_start(6'd3, 1'b0);
    chk("t4_mm_cleared", {58'b0, mismatch_cnt}, 64'd0);
    send_rec(recs[0]);
    wait_done("t4");
    chk("t4_all_writes", 64'(exp_q.size()), 64'd0);
    chk("t4_terr", {63'b0, timeout_err}, 64'd1);
    chk("t4_wb_mode_low", {63'b0, wb_mode}, 64'd0);
    chk("t4_cyc_low", {63'b0, wbm_cyc_o}, 64'd0);
    any_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_ready = any_ready | node_ready;
    end
    chk("t4_no_ready", {63'b0, any_ready}, 64'd0);
    no_ack_hi = 1'b0;

    // 5: stall in FETCH, stray start and spurious ack while busy
    rd0 = rd_beats;
    push_writes(3);
    pulse_start(6'd3, 1'b0);
    chk("t5_terr_cleared", {63'b0, timeout_err}, 64'd0);
    send_rec(recs[0]);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (node_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_fetch_reached", {63'b0, found}, 64'd1);
    beats0 = wr_beats + rd_beats;
    pulse_start(6'd1, 1'b1);
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_no_wb_while_stalled", 64'(wr_beats + rd_beats - beats0), 64'd0);
    chk("t5_still_ready", {63'b0, node_ready}, 64'd1);
    chk("t5_still_busy", {63'b0, busy}, 64'd1);
    send_rec(recs[1]);
    send_rec(recs[2]);
    wait_done("t5");
    chk("t5_all_writes", 64'(exp_q.size()), 64'd0);
    chk("t5_no_reads", 64'(rd_beats - rd0), 64'd0);
    chk("t5_terr", {63'b0, timeout_err}, 64'd0);

    // 6: async reset during the high read of node 2, then reload from node 0
    push_writes(3);
    pulse_start(6'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_rec(recs[i]);
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (wbm_cyc_o && !wbm_we_o && wbm_adr_o == 32'd497 && wbm_dat_o[11]) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_rd_hi_node2_reached", {63'b0, found}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cyc", {63'b0, wbm_cyc_o}, 64'd0);
    chk("t6_async_stb", {63'b0, wbm_stb_o}, 64'd0);
    chk("t6_async_wb_mode", {63'b0, wb_mode}, 64'd0);
    chk("t6_async_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_all_writes_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.push_back({32'd495, exp_lo[2]});
    exp_q.push_back({32'd495, exp_hi[2]});
    pulse_start(6'd1, 1'b0);
    send_rec(recs[2]);
    wait_done("t6");
    chk("t6_reload_writes", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
